burst_blink_seq: RTL
====================

Name: burst_blink_seq

Overview:
Parametrised successor to the single-LED three-state blink demo sequencer. Generates bursts of on/off pulses on NCH LED channels, with a prescaled timebase, a programmable burst length, an inter-burst gap, and an all-channel or chase mode. Exposes its prescaler tick, state, run count and timer so a top can drive the on-chip logic analyzer directly (tick as cqual; state/runs/timer as data_in).

Parameters:
NCH, 4, number of LED channels (>=1)
PRESCALE_W, 16, prescaler width; tick period = 2^PRESCALE_W clk cycles
TIMER_W, 8, phase timer width
RUNS_W, 4, run counter / burst_len width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  level; start/continue bursts
mode  in  1  0 = all channels together, 1 = chase (one channel per pulse)
on_time  in  TIMER_W  ON phase length in ticks
off_time  in  TIMER_W  OFF phase length in ticks
gap_time  in  TIMER_W  GAP phase length in ticks
burst_len  in  RUNS_W  pulses per burst; 0 = continuous
led  out  NCH  channel outputs
tick  out  1  prescaler qualifier, high when prescaler count == 0
state  out  4  one-hot state
runs  out  RUNS_W  pulses completed in the current burst
timer  out  TIMER_W  current phase timer
busy  out  1  high when state != IDLE
burst_done  out  1  one-cycle pulse on GAP exit

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: state = IDLE, led = 0, runs = 0, timer = 0, prescaler = 0, chase index = 0, burst_done = 0, latched config = 0. tick = 1 in the first cycle after reset (prescaler == 0).
- Prescaler: free-running PRESCALE_W-bit up-counter, wraps naturally. tick is combinational (prescaler == 0).
- Timer:
  - Decrements by 1 on a tick cycle when nonzero. Saturates at 0.
  - A load in the same cycle overrides the decrement.
  - Phase-exit conditions are evaluated every cycle, not only on tick cycles.
- States (one-hot): IDLE = 0001, ON = 0010, OFF = 0100, GAP = 1000. Unreachable encodings go to IDLE next cycle with led = 0.
- IDLE -> ON when enable = 1:
  - latch mode, on_time, off_time, gap_time and burst_len;
  - timer <= on_time; drive led per pattern.
- Pattern: mode 0 -> all NCH bits = 1. Mode 1 -> one-hot bit at chase index.
- ON, timer == 0:
  - led <= 0; runs <= runs + 1; chase index <= (index == NCH-1) ? 0 : index + 1.
  - If latched burst_len != 0 and runs + 1 == burst_len: go to GAP, timer <= gap_time, chase index <= 0.
  - Otherwise: go to OFF, timer <= off_time.
- Continuous mode (burst_len == 0): runs wraps modulo 2^RUNS_W. GAP is never entered.
- OFF, timer == 0 -> ON: timer <= latched on_time; led per pattern.
- GAP, timer == 0:
  - runs <= 0; burst_done = 1 for exactly this one cycle.
  - If enable = 1: relatch config and go to ON as from IDLE. Otherwise go to IDLE.
- enable = 0 in ON or OFF: next cycle go to IDLE; led = 0, runs = 0, timer = 0, chase index = 0. No burst_done. This takes priority over a same-cycle phase exit.
- enable = 0 in GAP: the gap completes normally, then the block goes to IDLE with burst_done pulsed.
- Config inputs are ignored except at the latch points. Mid-burst changes take effect at the next burst.
- A phase time of 0 gives a phase of exactly 1 cycle.
- A phase time of T >= 1 lasts between (T-1)*2^PRESCALE_W + 2 and T*2^PRESCALE_W + 1 cycles, depending on prescaler phase.
- rst asserted mid-operation: all registers return to reset values on that edge, including the prescaler.
- Outputs led, state, runs, timer, busy and burst_done are registered. tick is the only combinational output.

Test Plan:
(Bench parameters: NCH = 4, PRESCALE_W = 2, TIMER_W = 8, RUNS_W = 4.)
- Reset release, enable = 0 for 20 cycles -> state = 0001, led = 0000, busy = 0, tick high every 4th cycle starting at the first cycle.
- mode = 0, on = 2, off = 1, gap = 3, burst_len = 3, enable held -> led = 1111 three times, runs 1 -> 2 -> 3 then 0, one burst_done pulse, then the second burst starts in ON.
- mode = 1, on = off = 0, burst_len = 0 -> led steps 0001, 0010, 0100, 1000, 0001 with one cycle per ON phase; runs wraps 15 -> 0; burst_done never asserts.
- Drop enable during the second ON of a burst -> state = 0001 and led = 0000 on the next cycle, runs = 0, no burst_done. Drop enable during GAP instead -> GAP completes, burst_done pulses once, then IDLE.
- Change on_time from 2 to 5 mid-burst -> the remaining pulses keep 2 ticks; the next burst uses 5.
- Assert rst while in OFF with timer = 3 -> next cycle all outputs at reset values and the prescaler back at 0.

Source files
------------

// File: rtl/burst_blink_seq.sv
// Burst/chase LED sequencer with a prescaled timebase. It exposes tick, state, runs and timer
// so a logic analyzer can use them directly.
module burst_blink_seq #(
  parameter int NCH        = 4,
  parameter int PRESCALE_W = 16,
  parameter int TIMER_W    = 8,
  parameter int RUNS_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic [TIMER_W-1:0] on_time,
  input  logic [TIMER_W-1:0] off_time,
  input  logic [TIMER_W-1:0] gap_time,
  input  logic [RUNS_W-1:0]  burst_len,
  output logic [NCH-1:0]     led,
  output logic               tick,
  output logic [3:0]         state,
  output logic [RUNS_W-1:0]  runs,
  output logic [TIMER_W-1:0] timer,
  output logic               busy,
  output logic               burst_done
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_ON   = 4'b0010;
  localparam logic [3:0] S_OFF  = 4'b0100;
  localparam logic [3:0] S_GAP  = 4'b1000;

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [3:0]            state_q, state_d;
  logic [NCH-1:0]        led_q, led_d;
  logic [RUNS_W-1:0]     runs_q, runs_d, runs_inc;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [IW-1:0]         idx_q, idx_d, idx_inc;
  logic                  bd_q, bd_d;
  logic                  busy_q, busy_d;
  logic                  mode_q, mode_d;
  logic [TIMER_W-1:0]    on_q, on_d, off_q, off_d, gap_q, gap_d;
  logic [RUNS_W-1:0]     blen_q, blen_d;
  logic                  start;

  function automatic logic [NCH-1:0] pattern(input logic m, input logic [IW-1:0] idx);
    if (m) pattern = NCH'(1) << idx;
    else   pattern = '1;
  endfunction

  assign tick     = (presc_q == '0);
  assign runs_inc = runs_q + 1'b1;
  assign idx_inc  = (idx_q == IW'(NCH - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    presc_d = presc_q + 1'b1;
    state_d = state_q;
    led_d   = led_q;
    runs_d  = runs_q;
    idx_d   = idx_q;
    bd_d    = 1'b0;
    mode_d  = mode_q;
    on_d    = on_q;
    off_d   = off_q;
    gap_d   = gap_q;
    blen_d  = blen_q;
    start   = 1'b0;
    // A load further down overrides this saturating decrement.
    timer_d = (tick && timer_q != '0) ? timer_q - 1'b1 : timer_q;

    case (state_q)
      S_IDLE: start = enable;
      S_ON: begin
        if (!enable) begin
          state_d = S_IDLE;
          led_d   = '0;
          runs_d  = '0;
          timer_d = '0;
          idx_d   = '0;
        end else if (timer_q == '0) begin
          led_d  = '0;
          runs_d = runs_inc;
          if (blen_q != '0 && runs_inc == blen_q) begin
            state_d = S_GAP;
            timer_d = gap_q;
            idx_d   = '0;
          end else begin
            state_d = S_OFF;
            timer_d = off_q;
            idx_d   = idx_inc;
          end
        end
      end
      S_OFF: begin
        if (!enable) begin
          state_d = S_IDLE;
          led_d   = '0;
          runs_d  = '0;
          timer_d = '0;
          idx_d   = '0;
        end else if (timer_q == '0) begin
          state_d = S_ON;
          timer_d = on_q;
          led_d   = pattern(mode_q, idx_q);
        end
      end
      S_GAP: begin
        // The gap always runs to completion; enable only picks the successor.
        if (timer_q == '0) begin
          runs_d  = '0;
          bd_d    = 1'b1;
          state_d = S_IDLE;
          start   = enable;
        end
      end
      default: begin
        state_d = S_IDLE;
        led_d   = '0;
      end
    endcase

    if (start) begin
      mode_d  = mode;
      on_d    = on_time;
      off_d   = off_time;
      gap_d   = gap_time;
      blen_d  = burst_len;
      state_d = S_ON;
      timer_d = on_time;
      led_d   = pattern(mode, idx_q);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      state_q <= S_IDLE;
      led_q   <= '0;
      runs_q  <= '0;
      timer_q <= '0;
      idx_q   <= '0;
      bd_q    <= 1'b0;
      busy_q  <= 1'b0;
      mode_q  <= 1'b0;
      on_q    <= '0;
      off_q   <= '0;
      gap_q   <= '0;
      blen_q  <= '0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      led_q   <= led_d;
      runs_q  <= runs_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      bd_q    <= bd_d;
      busy_q  <= busy_d;
      mode_q  <= mode_d;
      on_q    <= on_d;
      off_q   <= off_d;
      gap_q   <= gap_d;
      blen_q  <= blen_d;
    end
  end

  assign led        = led_q;
  assign state      = state_q;
  assign runs       = runs_q;
  assign timer      = timer_q;
  assign busy       = busy_q;
  assign burst_done = bd_q;

endmodule
